// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator/capture pair: FSM states,
// the full-scale duty magnitude and the sign convention (dir=1 -> positive).
package pwm_pkg;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    HIGH      = 2'd1,
    LOW       = 2'd2
  } pwm_state_t;

  // Largest positive duty magnitude for a signed word of the given width.
  function automatic logic [63:0] dty_max(input int unsigned width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] apply_sign(input logic [63:0] mag, input logic pos);
    return pos ? mag : (64'd0 - mag);
  endfunction

endpackage

// File: rtl/pwm_capture_sync.sv
// Pin synchronisers for pwm/dir, optional glitch filter on pwm
// (PWM_CAPTURE_FILTER_EN) and rise/fall detection on the clean level.
module pwm_capture_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm,
  input  logic dir,
  output logic level,
  output logic dir_s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] pwm_ff;
  logic [SYNC_STAGES-1:0] dir_ff;
  logic                   pwm_s;
  logic                   prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_ff <= '0;
      dir_ff <= '0;
    end else begin
      pwm_ff <= {pwm_ff[SYNC_STAGES-2:0], pwm};
      dir_ff <= {dir_ff[SYNC_STAGES-2:0], dir};
    end
  end

  assign pwm_s = pwm_ff[SYNC_STAGES-1];
  assign dir_s = dir_ff[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);

  logic [FW-1:0] flt_cnt;
  logic          flt;

  // Flip only after FILTER_LEN consecutive samples disagree with the current level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_cnt <= '0;
      flt     <= 1'b0;
    end else if (pwm_s == flt) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
      flt_cnt <= '0;
      flt     <= pwm_s;
    end else begin
      flt_cnt <= flt_cnt + FW'(1);
    end
  end

  assign level = flt;
`else
  assign level = pwm_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= level;
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/pwm_capture.sv
// PWM/direction receiver: measures high time and period between rises and
// reports a signed duty word. Optional glitch filter: PWM_CAPTURE_FILTER_EN.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1000000,
  parameter int FILTER_LEN  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm,
  input  logic             dir,
  output logic [WIDTH-1:0] dty,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] DTY_MAX = WIDTH'(dty_max(WIDTH));
  localparam int               TW      = $clog2(TIMEOUT + 1);

  logic             level;
  logic             dir_s;
  logic             rise;
  logic             fall;
  pwm_state_t       state;
  pwm_state_t       state_nx;
  logic             latch;
  logic             expire;
  logic [WIDTH-1:0] high_cnt;
  logic [WIDTH-1:0] per_cnt;
  logic [TW-1:0]    tmo_cnt;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v == DTY_MAX) ? v : v + WIDTH'(1);
  endfunction

  pwm_capture_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pwm   (pwm),
    .dir   (dir),
    .level (level),
    .dir_s (dir_s),
    .rise  (rise),
    .fall  (fall)
  );

  // An edge in the expiry cycle wins, so expire never coincides with a rise.
  assign expire = (tmo_cnt == TW'(TIMEOUT - 1)) && !(rise || fall);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              tmo_cnt <= '0;
    else if (rise || fall)   tmo_cnt <= '0;
    else if (tmo_cnt != TW'(TIMEOUT)) tmo_cnt <= tmo_cnt + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_RISE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    latch    = 1'b0;
    unique case (state)
      WAIT_RISE: if (rise) state_nx = HIGH;
      HIGH:      if (fall) state_nx = LOW;
      LOW: begin
        if (rise) begin
          state_nx = HIGH;
          latch    = 1'b1;
        end
      end
      default:   state_nx = WAIT_RISE;
    endcase
    if (expire) state_nx = WAIT_RISE;
  end

  // The cycle a fall is seen already belongs to the low phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_cnt <= '0;
      per_cnt  <= '0;
    end else if (rise) begin
      high_cnt <= WIDTH'(1);
      per_cnt  <= WIDTH'(1);
    end else begin
      unique case (state)
        HIGH: begin
          per_cnt <= sat_inc(per_cnt);
          if (!fall) high_cnt <= sat_inc(high_cnt);
        end
        LOW:     per_cnt <= sat_inc(per_cnt);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dty     <= '0;
      period  <= '0;
      valid   <= 1'b0;
      timeout <= 1'b1;
    end else begin
      valid <= latch;
      if (latch) begin
        period  <= per_cnt;
        dty     <= WIDTH'(apply_sign(64'(high_cnt), dir_s));
        timeout <= 1'b0;
      end else if (expire) begin
        period  <= '0;
        dty     <= level ? WIDTH'(apply_sign(64'(DTY_MAX), dir_s)) : '0;
        timeout <= 1'b1;
      end
    end
  end

endmodule
